// File: rtl/half_adder_gatelevel_if.sv
// Operand/result bundle for the half-adder bank: master drives operands, slave returns results.
// Carries both the zero-latency combinational results and the one-cycle registered copy.
interface half_adder_gatelevel_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             in_valid;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] carry_q;
   logic             out_valid;

   modport master (
      output in1,
      output in2,
      output in_valid,
      input  sum,
      input  carry,
      input  sum_q,
      input  carry_q,
      input  out_valid
   );

   modport slave (
      input  in1,
      input  in2,
      input  in_valid,
      output sum,
      output carry,
      output sum_q,
      output carry_q,
      output out_valid
   );
endinterface

// File: rtl/half_adder_gatelevel.sv
// Bank of WIDTH independent gate-level half adders; comb outputs at zero latency, registered copy one cycle later.
// No backpressure: in_valid captures every cycle it is high, otherwise registers hold and out_valid drops.
module half_adder_gatelevel #(
   parameter int WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   half_adder_gatelevel_if.slave bus
);
   wire [WIDTH-1:0] in1_w;
   wire [WIDTH-1:0] in2_w;
   wire [WIDTH-1:0] sum_w;
   wire [WIDTH-1:0] carry_w;

   logic [WIDTH-1:0] sum_d;
   logic [WIDTH-1:0] carry_d;
   logic             out_valid_d;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] carry_q;
   logic             out_valid_q;

   assign in1_w = bus.in1;
   assign in2_w = bus.in2;

   // Primitives keep X/Z semantics exact: an AND with a known 0 still yields carry 0.
   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_lane
         xor u_xor (sum_w[i], in1_w[i], in2_w[i]);
         and u_and (carry_w[i], in1_w[i], in2_w[i]);
      end
   endgenerate

   always_comb begin
      sum_d       = sum_q;
      carry_d     = carry_q;
      out_valid_d = 1'b0;
      if (bus.in_valid) begin
         sum_d       = sum_w;
         carry_d     = carry_w;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q       <= '0;
         carry_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.sum       = sum_w;
   assign bus.carry     = carry_w;
   assign bus.sum_q     = sum_q;
   assign bus.carry_q   = carry_q;
   assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_half_adder_gatelevel.sv
// Directed plus randomized bench for the half-adder bank at WIDTH 1, 4 and 8 against an arithmetic lane model.
module tb_half_adder_gatelevel;
   logic clk;
   logic rst_n;

   half_adder_gatelevel_if #(.WIDTH(1)) if1 ();
   half_adder_gatelevel_if #(.WIDTH(4)) if4 ();
   half_adder_gatelevel_if #(.WIDTH(8)) if8 ();

   half_adder_gatelevel #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   half_adder_gatelevel #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
   half_adder_gatelevel #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

   int pass_cnt = 0;
   int total    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Each lane adds two one-bit numbers; the two-bit result splits into sum (LSB) and carry (MSB).
   function automatic void ref_add(input logic [7:0] a, input logic [7:0] b, input int w,
                                   output logic [7:0] s, output logic [7:0] c);
      s = '0;
      c = '0;
      for (int k = 0; k < w; k++) begin
         int t;
         t = int'(a[k]) + int'(b[k]);
         s[k] = (t % 2) == 1;
         c[k] = (t / 2) == 1;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] es, ec, rs, rc;
   logic [1:0] pa [4];
   logic [7:0] x;
   logic       rv;
   logic [7:0] exp_sq, exp_cq;
   logic       exp_ov;

   initial begin
      pa[0] = 2'b00; pa[1] = 2'b01; pa[2] = 2'b10; pa[3] = 2'b11;
      rst_n = 1'b0;
      if1.in1 = '0; if1.in2 = '0; if1.in_valid = 1'b0;
      if4.in1 = '0; if4.in2 = '0; if4.in_valid = 1'b0;
      if8.in1 = '0; if8.in2 = '0; if8.in_valid = 1'b0;

      // Combinational truth table, 10 ns per step, no dependence on the clock.
      for (int p = 0; p < 4; p++) begin
         if1.in1 = pa[p][1];
         if1.in2 = pa[p][0];
         #10;
         ref_add({7'd0, pa[p][1]}, {7'd0, pa[p][0]}, 1, es, ec);
         chk("comb_w1_sum", 32'(if1.sum), 32'(es[0]));
         chk("comb_w1_carry", 32'(if1.carry), 32'(ec[0]));
      end
      #30;

      // Reset held for two cycles with valid operands present.
      if1.in1 = 1'b1; if1.in2 = 1'b1; if1.in_valid = 1'b1;
      for (int r = 0; r < 2; r++) begin
         tick();
         chk("rst_sum_q", 32'(if1.sum_q), 32'd0);
         chk("rst_carry_q", 32'(if1.carry_q), 32'd0);
         chk("rst_out_valid", 32'(if1.out_valid), 32'd0);
      end

      // Release reset with in_valid high; four pairs back to back.
      rst_n = 1'b1;
      for (int p = 0; p < 4; p++) begin
         if1.in1 = pa[p][1];
         if1.in2 = pa[p][0];
         if1.in_valid = 1'b1;
         ref_add({7'd0, pa[p][1]}, {7'd0, pa[p][0]}, 1, es, ec);
         tick();
         chk("seq_sum_q", 32'(if1.sum_q), 32'(es[0]));
         chk("seq_carry_q", 32'(if1.carry_q), 32'(ec[0]));
         chk("seq_out_valid", 32'(if1.out_valid), 32'd1);
      end

      // Idle after (1,1): registers hold 0/1, out_valid low.
      if1.in_valid = 1'b0;
      if1.in1 = 1'b0; if1.in2 = 1'b1;
      for (int r = 0; r < 2; r++) begin
         tick();
         chk("hold_sum_q", 32'(if1.sum_q), 32'd0);
         chk("hold_carry_q", 32'(if1.carry_q), 32'd1);
         chk("hold_out_valid", 32'(if1.out_valid), 32'd0);
      end

      // Reset mid-stream discards the capture on that edge.
      if1.in_valid = 1'b1;
      rst_n = 1'b0;
      tick();
      chk("midrst_sum_q", 32'(if1.sum_q), 32'd0);
      chk("midrst_carry_q", 32'(if1.carry_q), 32'd0);
      chk("midrst_out_valid", 32'(if1.out_valid), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("postrst_sum_q", 32'(if1.sum_q), 32'd1);
      chk("postrst_out_valid", 32'(if1.out_valid), 32'd1);
      if1.in_valid = 1'b0;

      // WIDTH=8 directed vector.
      if8.in1 = 8'hF0; if8.in2 = 8'hCC; if8.in_valid = 1'b1;
      #1;
      chk("w8_sum", 32'(if8.sum), 32'h3C);
      chk("w8_carry", 32'(if8.carry), 32'hC0);
      tick();
      chk("w8_sum_q", 32'(if8.sum_q), 32'h3C);
      chk("w8_carry_q", 32'(if8.carry_q), 32'hC0);
      chk("w8_out_valid", 32'(if8.out_valid), 32'd1);
      if8.in_valid = 1'b0;

      // Exhaustive WIDTH=4 sweep, back to back.
      for (int n = 0; n < 256; n++) begin
         x = 8'(n);
         if4.in1 = x[7:4];
         if4.in2 = x[3:0];
         if4.in_valid = 1'b1;
         ref_add({4'd0, x[7:4]}, {4'd0, x[3:0]}, 4, es, ec);
         #1;
         chk("w4_sum", 32'(if4.sum), 32'(es[3:0]));
         chk("w4_carry", 32'(if4.carry), 32'(ec[3:0]));
         chk("w4_exclusive", 32'(if4.sum & if4.carry), 32'd0);
         tick();
         chk("w4_sum_q", 32'(if4.sum_q), 32'(es[3:0]));
         chk("w4_carry_q", 32'(if4.carry_q), 32'(ec[3:0]));
         chk("w4_out_valid", 32'(if4.out_valid), 32'd1);
      end
      if4.in_valid = 1'b0;

      // Randomized WIDTH=8 traffic with random valid gaps.
      tick();
      exp_sq = 8'h3C; exp_cq = 8'hC0; exp_ov = 1'b0;
      for (int n = 0; n < 200; n++) begin
         rs = 8'($urandom);
         rc = 8'($urandom);
         rv = 1'($urandom_range(0, 1));
         if8.in1 = rs; if8.in2 = rc; if8.in_valid = rv;
         ref_add(rs, rc, 8, es, ec);
         #1;
         chk("rnd_sum", 32'(if8.sum), 32'(es));
         chk("rnd_carry", 32'(if8.carry), 32'(ec));
         if (rv) begin
            exp_sq = es;
            exp_cq = ec;
         end
         exp_ov = rv;
         tick();
         chk("rnd_sum_q", 32'(if8.sum_q), 32'(exp_sq));
         chk("rnd_carry_q", 32'(if8.carry_q), 32'(exp_cq));
         chk("rnd_out_valid", 32'(if8.out_valid), 32'(exp_ov));
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/half_adder_gatelevel.md
Name: half_adder_gatelevel

Overview:
- Bank of WIDTH independent 1-bit half adders, built structurally from gate primitives.
- Each lane takes in1[i] and in2[i] and produces sum[i] = in1[i] XOR in2[i] and carry[i] = in1[i] AND in2[i].
- Combinational outputs are available immediately; a registered copy with a valid flag is provided for pipelined datapaths.
- Used as the leaf arithmetic cell under full adders and ripple/compressor trees.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (≥1).

Ports:
- clk  input  1  system clock; registered outputs update on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in1  input  WIDTH  operand A, one bit per lane.
- in2  input  WIDTH  operand B, one bit per lane.
- in_valid  input  1  qualifies in1/in2 for capture into the output registers.
- sum  output  WIDTH  combinational sum, in1 ^ in2 per lane.
- carry  output  WIDTH  combinational carry, in1 & in2 per lane.
- sum_q  output  WIDTH  registered sum.
- carry_q  output  WIDTH  registered carry.
- out_valid  output  1  high when sum_q/carry_q hold a result captured on the previous cycle.

Behaviour:
- Combinational path:
  - Purely structural gate-level: one XOR primitive and one AND primitive per lane, generated over WIDTH.
  - No behavioural operators on this path.
  - Zero clock latency; independent of clk, rst_n and in_valid.
  - Must settle correctly with clk/rst_n left unconnected.
- Lane truth table: 0,0 → sum 0, carry 0; 0,1 → 1,0; 1,0 → 1,0; 1,1 → 0,1.
- Lanes are fully independent; no carry propagates between lanes.
- X/Z on either input bit of a lane yields X on that lane's sum and carry only. Carry is 0 if the other bit is 0, per primitive semantics.
- Registered path, on rising clk:
  - rst_n == 0: sum_q, carry_q and out_valid all clear to 0, regardless of in_valid.
  - Else if in_valid == 1: sum_q ← sum, carry_q ← carry, out_valid ← 1.
  - Else: sum_q and carry_q hold their value; out_valid ← 0.
- Latency is exactly one cycle from an in_valid=1 edge to out_valid=1 with the matching data.
- Back-to-back in_valid gives one result per cycle, with no bubbles or stalls.
- Reset asserted mid-stream:
  - The result being captured on that edge is discarded.
  - out_valid is 0 on the cycle following reset.
- in_valid asserted in the same cycle reset is released (rst_n rising) is captured normally on the next edge where rst_n == 1.
- Invariant on every lane, both paths: sum and carry are never simultaneously 1.
- Reset values: sum_q = 0, carry_q = 0, out_valid = 0. Combinational outputs have no reset value and always track the inputs.

Test Plan:
- WIDTH=1, no clock, inputs applied 10 ns apart: (0,0), (0,1), (1,0), (1,1) → (sum,carry) = (0,0), (1,0), (1,0), (0,1) after each step. Hold 30 ns after the last step, then finish.
- WIDTH=1, clocked: hold rst_n=0 for 2 cycles with in_valid=1 and in1=in2=1 → sum_q=0, carry_q=0, out_valid=0 throughout.
- Release reset; present the four input pairs on consecutive cycles with in_valid=1 → sum_q/carry_q follow the truth table, each one cycle later, with out_valid=1 for 4 consecutive cycles.
- Drop in_valid for 2 cycles after the input pair (1,1) → out_valid=0 and sum_q/carry_q hold 0/1.
- WIDTH=8: in1=8'hF0, in2=8'hCC → sum=8'h3C, carry=8'hC0 combinationally; the same values appear on sum_q/carry_q one cycle after in_valid.
- Exhaustive WIDTH=4 sweep of all 256 operand pairs → per-lane truth table holds, sum & carry == 0, and registered outputs match the combinational outputs delayed by one cycle.
